// File: rtl/shiftreg_pkg.sv
// Shared definitions for the universal shift register: operation encodings,
// burst FSM states and a helper that classifies shift-type operations.
package shiftreg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHR  = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_ROR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_LOAD = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_CLR  = 3'b111
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Only movement operations may be repeated by a counted burst.
    function automatic logic is_shift_mode(input logic [2:0] mode);
        return (mode == MODE_SHR) || (mode == MODE_SHL) || (mode == MODE_ROR) ||
               (mode == MODE_ROL) || (mode == MODE_ASR);
    endfunction

endpackage

// File: rtl/univ_shiftreg_if.sv
// Control/data bundle of the universal shift register. The master drives the
// operation request; the slave (the register itself) returns contents and status.
interface univ_shiftreg_if #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
);
    logic          EN;
    logic [2:0]    MODE;
    logic          SIN_R;
    logic          SIN_L;
    logic [N-1:0]  D;
    logic          START;
    logic [CW-1:0] CNT;
    logic [N-1:0]  Q;
    logic          SOUT_R;
    logic          SOUT_L;
    logic          BUSY;
    logic          DONE;

    modport master (
        output EN, MODE, SIN_R, SIN_L, D, START, CNT,
        input  Q, SOUT_R, SOUT_L, BUSY, DONE
    );

    modport slave (
        input  EN, MODE, SIN_R, SIN_L, D, START, CNT,
        output Q, SOUT_R, SOUT_L, BUSY, DONE
    );
endinterface

// File: rtl/usr_next_val.sv
// Combinational next-contents function of the shift register, shared by the
// single-operation path and the burst path.
module usr_next_val
    import shiftreg_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] q_i,
    input  logic [2:0]   mode_i,
    input  logic         sin_r_i,
    input  logic         sin_l_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    always_comb begin
        q_o = q_i;
        case (mode_i)
            MODE_HOLD: q_o = q_i;
            MODE_SHR:  q_o = {sin_r_i, q_i[N-1:1]};
            MODE_SHL:  q_o = {q_i[N-2:0], sin_l_i};
            MODE_ROR:  q_o = {q_i[0], q_i[N-1:1]};
            MODE_ROL:  q_o = {q_i[N-2:0], q_i[N-1]};
            MODE_LOAD: q_o = d_i;
            MODE_ASR:  q_o = {q_i[N-1], q_i[N-1:1]};
            MODE_CLR:  q_o = '0;
            default:   q_o = q_i;
        endcase
    end

endmodule

// File: rtl/univ_shiftreg.sv
// N-bit universal shift register with single operations and a counted burst
// mode that repeats a latched shift operation and pulses DONE on completion.
module univ_shiftreg
    import shiftreg_pkg::*;
#(
    parameter int           N         = 8,
    parameter logic [N-1:0] RESET_VAL = {N{1'b0}},
    parameter int           CW        = $clog2(N + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    univ_shiftreg_if.slave bus
);

    state_e        state_q, state_d;
    logic [N-1:0]  q_q, q_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [2:0]    lmode_q, lmode_d;
    logic          done_q, done_d;
    logic [2:0]    op_mode;
    logic [N-1:0]  q_nxt;

    // A burst replays the latched mode; a zero-length burst must leave Q alone.
    always_comb begin
        op_mode = bus.MODE;
        if (state_q == ST_BURST) begin
            op_mode = lmode_q;
        end else if (bus.START && is_shift_mode(bus.MODE) && (bus.CNT == '0)) begin
            op_mode = MODE_HOLD;
        end
    end

    usr_next_val #(.N(N)) u_next (
        .q_i     (q_q),
        .mode_i  (op_mode),
        .sin_r_i (bus.SIN_R),
        .sin_l_i (bus.SIN_L),
        .d_i     (bus.D),
        .q_o     (q_nxt)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rem_d   = rem_q;
        lmode_d = lmode_q;
        done_d  = 1'b0;
        if (bus.EN) begin
            q_d = q_nxt;
            case (state_q)
                ST_IDLE: begin
                    if (bus.START && is_shift_mode(bus.MODE)) begin
                        lmode_d = bus.MODE;
                        if (bus.CNT == '0 || bus.CNT == CW'(1)) begin
                            done_d = 1'b1;
                        end else begin
                            rem_d   = bus.CNT - CW'(1);
                            state_d = ST_BURST;
                        end
                    end
                end
                ST_BURST: begin
                    rem_d = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            q_q     <= RESET_VAL;
            rem_q   <= '0;
            lmode_q <= MODE_HOLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            lmode_q <= lmode_d;
            done_q  <= done_d;
        end
    end

    assign bus.Q      = q_q;
    assign bus.SOUT_R = q_q[0];
    assign bus.SOUT_L = q_q[N-1];
    assign bus.BUSY   = (state_q == ST_BURST);
    assign bus.DONE   = done_q;

endmodule

// File: tb/tb_univ_shiftreg.sv
// Bench for univ_shiftreg (N=4): directed scenarios followed by random traffic,
// all checked against an arithmetic reference model of the register.
module tb_univ_shiftreg;

    localparam int          N  = 4;
    localparam int          CW = $clog2(N + 1);
    localparam logic [3:0]  RV = 4'b1010;

    logic CLK = 1'b0;
    logic RST;

    univ_shiftreg_if #(.N(N), .CW(CW)) bus ();

    univ_shiftreg #(.N(N), .RESET_VAL(RV), .CW(CW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference state: contents, shifts still owed by a burst, burst mode, DONE.
    int m_q    = 0;
    int m_rem  = 0;
    int m_mode = 0;
    bit m_done = 0;

    function automatic int apply_op(int mode, int q, int sr, int sl, int d);
        case (mode)
            1: return (q / 2) + sr * 8;
            2: return ((q * 2) % 16) + sl;
            3: return (q / 2) + (q % 2) * 8;
            4: return ((q * 2) % 16) + (q / 8);
            5: return d;
            6: return (q / 2) + ((q >= 8) ? 8 : 0);
            7: return 0;
            default: return q;
        endcase
    endfunction

    function automatic bit is_shift(int mode);
        return mode == 1 || mode == 2 || mode == 3 || mode == 4 || mode == 6;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit en, input int mode, input bit sr,
                        input bit sl, input int d, input bit start, input int cnt);
        bit nd;
        RST       = rst;
        bus.EN    = en;
        bus.MODE  = 3'(mode);
        bus.SIN_R = sr;
        bus.SIN_L = sl;
        bus.D     = 4'(d);
        bus.START = start;
        bus.CNT   = CW'(cnt);
        @(posedge CLK);
        nd = 0;
        if (rst) begin
            m_q = int'(RV); m_rem = 0;
        end else if (en) begin
            if (m_rem > 0) begin
                m_q = apply_op(m_mode, m_q, sr, sl, d);
                m_rem--;
                if (m_rem == 0) nd = 1;
            end else if (start && is_shift(mode)) begin
                m_mode = mode;
                if (cnt == 0) nd = 1;
                else begin
                    m_q   = apply_op(mode, m_q, sr, sl, d);
                    m_rem = cnt - 1;
                    if (cnt == 1) nd = 1;
                end
            end else begin
                m_q = apply_op(mode, m_q, sr, sl, d);
            end
        end
        m_done = nd;
        #1;
        check("Q", bus.Q, 4'(m_q));
        check("BUSY", {3'b0, bus.BUSY}, {3'b0, m_rem > 0});
        check("DONE", {3'b0, bus.DONE}, {3'b0, m_done});
        check("SOUT_R", {3'b0, bus.SOUT_R}, {3'b0, 1'(m_q % 2)});
        check("SOUT_L", {3'b0, bus.SOUT_L}, {3'b0, 1'(m_q / 8)});
        $display("step rst=%0b en=%0b mode=%0d start=%0b cnt=%0d -> Q=%b busy=%0b done=%0b",
                 rst, en, mode, start, cnt, bus.Q, bus.BUSY, bus.DONE);
    endtask

    initial begin
        // Reset and enable-low freeze
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("rst_Q_const", bus.Q, 4'b1010);
        repeat (3) step(0, 0, 1, 1, 1, 15, 0, 0);
        // Single operations from 1010
        step(0, 1, 1, 1, 0, 0, 0, 0);
        check("shr_const", bus.Q, 4'b1101);
        step(0, 1, 6, 0, 0, 0, 0, 0);
        check("asr_const", bus.Q, 4'b1110);
        step(0, 1, 4, 0, 0, 0, 0, 0);
        check("rol_const", bus.Q, 4'b1101);
        step(0, 1, 2, 0, 0, 0, 0, 0);
        check("shl_const", bus.Q, 4'b1010);
        // Load then rotate-left burst of 3
        step(0, 1, 5, 0, 0, 1, 0, 0);
        step(0, 1, 4, 0, 0, 0, 1, 3);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        check("rol_burst_end", bus.Q, 4'b1000);
        // Shift-right burst of 4 with a two-cycle enable gap
        step(0, 1, 7, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0, 1, 4);
        step(0, 1, 5, 1, 0, 3, 1, 2);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        check("gap_hold", bus.Q, 4'b1100);
        step(0, 1, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0);
        check("gap_end", bus.Q, 4'b1111);
        // Zero-length burst and ignored START with load
        step(0, 1, 2, 0, 0, 0, 1, 0);
        step(0, 1, 5, 0, 0, 6, 1, 3);
        // Reset mid-burst, then a fresh burst
        step(0, 1, 3, 0, 0, 0, 1, 4);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 2, 0, 1, 0, 1, 2);
        step(0, 1, 0, 0, 1, 0, 0, 0);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 40) == 0, $urandom_range(0, 4) != 0,
                 int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 7)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
